syncfifo_gather_4: RTL and testbench
====================================

Name: syncfifo_gather_4

Overview:
- 4-to-1 merging FIFO, the mirror of the shared 4-destination split FIFO.
- Four independent producers may each present one word per cycle. Accepted words go into one shared circular buffer in arrival order; within one cycle, lower input index comes first.
- A single consumer pops words in that order. Each popped word carries a 2-bit source tag naming its input.
- Sits at the point where per-destination streams rejoin into one stream.

Parameters:
- WID, 32, data width per word.
- DEPTH, 8, buffer entries. Power of two, 4 or more.
- AWID, $clog2(DEPTH), localparam, pointer width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- softreset  input  1  synchronous flush of pointers and count.
- vldin  input  4  per-input valid.
- din  input  [3:0][WID]  per-input data.
- ready  output  4  per-input accept, combinational.
- readout  input  1  pop request.
- dout  output  WID  head data; 0 when empty.
- source  output  2  head source index; 0 when empty.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- count  output  16  occupancy, zero-extended.
- overflow  output  1  combinational: |(vldin & ~ready).

Behaviour:
- State:
  - wptr, rptr: AWID bits, wrap mod DEPTH.
  - cnt: AWID+1 bits.
  - mem[DEPTH] of {src[1:0], data[WID-1:0]}.
- Reset (rst=1): wptr=rptr=cnt=0. Outputs: empty=1, full=0, count=0, dout=0, source=0, ready=0, overflow=|vldin. mem is not cleared.
- softreset=1: same register effect as rst. ready forced 0. Any writes and pops in that cycle are discarded. rst and softreset both override everything else.
- Admission, combinational, computed from current cnt only:
  - free = DEPTH-cnt.
  - pre[i] = popcount(vldin[i-1:0]).
  - ready[i] = free > pre[i].
  - acc[i] = vldin[i] & ready[i].
  - Lower index has strict priority.
  - A pop in the same cycle does NOT create room. When full, ready=0 even with readout=1.
- Write: accepted input i goes to mem[(wptr + popcount(acc[i-1:0])) mod DEPTH] with src=i. Then wptr += nacc, where nacc = popcount(acc), 0..4.
- Pop: pop = readout & !empty. It returns mem[rptr] on dout/source combinationally in the same cycle; rptr advances at the clock edge. readout while empty is ignored, with no state change.
- Count: cnt_next = cnt + nacc - pop, as one arithmetic update. Legal range is 0..DEPTH, never exceeded by construction.
- Latency: a word written at edge t is visible on dout from cycle t+1. There is no bypass.
- Ordering: strictly global arrival order. No per-source reordering.
- ready has a combinational path from vldin. Producers must not make vldin depend on ready.

Optional Feature:
- SYNCFIFO_GATHER_DROPCNT_EN: adds output drops [3:0][7:0].
  - drops[i] increments when vldin[i]&!ready[i], saturating at 255.
  - Cleared by rst and softreset.
  - Not counted while rst or softreset is high.
- Without the macro: the port and its registers are absent. All other behaviour is identical.

Decomposition:
- Package syncfifo_pkg holds:
  - localparam NPORTS=4 and SRC_W=2;
  - typedef gather_entry_t (packed struct {src, data}), parameterized through the module by using data width WID.
- Sub-module gather_prefix_4: purely combinational. Input 4-bit mask; outputs prefix counts pre[0..3] (3 bits each) and total (3 bits). Instantiated twice: once on vldin for ready, once on acc for write offsets and nacc.

Test Plan:
1. Reset: rst=1 for 2 cycles with vldin=4'hF -> ready=0, empty=1, full=0, count=0, dout=0, source=0. After release with vldin=0: ready stays 0 until vldin rises, then ready=vldin.
2. Burst-4 ordering: DEPTH=8, empty, one cycle vldin=4'hF, din=A,B,C,D -> next cycle count=4. Pops return A/0, B/1, C/2, D/3, then empty=1.
3. Partial admission: cnt=6, vldin=4'hF -> ready=4'b0011, overflow=1. Next cycle count=8, full=1. Last two entries are inputs 0 and 1.
4. Full plus simultaneous pop: full, readout=1, vldin=4'b0001 -> ready[0]=0, overflow=1. Next cycle count=7 and head advances by one.
5. Wrap-around: wptr=6, rptr=6, empty; vldin=4'b1011 with X,Y,Z -> stored at slots 6, 7, 0 with src 0, 1, 3. Pops return X/0, Y/1, Z/3; wptr=1.
6. Softreset mid-traffic: count=5, softreset=1 with vldin=4'hF and readout=1 -> ready=0. Next cycle count=0, empty=1, wptr=rptr=0. With SYNCFIFO_GATHER_DROPCNT_EN defined: drops all 0, and a later blocked vldin[2] for 300 cycles saturates drops[2] at 255.

Source files
------------

// File: rtl/syncfifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : syncfifo_pkg
// Description : Shared constants for the 4-to-1 gather FIFO slice.
//               The stored entry type {src, data} depends on the FIFO data
//               width, so it is declared inside syncfifo_gather_4 using its
//               WID parameter; this package fixes the source-tag and
//               prefix-count widths that entry type is built from.
// Revision    : 1.0 - initial release
// ============================================================================
package syncfifo_pkg;

  localparam int NPORTS = 4;  // producer inputs
  localparam int SRC_W  = 2;  // source tag width, log2(NPORTS)
  localparam int PCNT_W = 3;  // prefix / total popcount width, holds 0..4

endpackage
`default_nettype wire

// File: rtl/gather_prefix_4.sv
`default_nettype none
// ============================================================================
// Module      : gather_prefix_4
// Description : Exclusive prefix popcount of a 4-bit mask.
//               pre_o[i] = number of set bits in mask_i[i-1:0];
//               total_o  = number of set bits in mask_i.
// Ports       : mask_i  [3:0]       input mask
//               pre_o   [3:0][2:0]  exclusive prefix counts
//               total_o [2:0]       total count (0..4)
// Revision    : 1.0 - initial release
// ============================================================================
module gather_prefix_4
  import syncfifo_pkg::*;
(
  input  logic [NPORTS-1:0]             mask_i,
  output logic [NPORTS-1:0][PCNT_W-1:0] pre_o,
  output logic [PCNT_W-1:0]             total_o
);

  logic [PCNT_W-1:0] run;

  always_comb begin
    run = '0;
    for (int i = 0; i < NPORTS; i++) begin
      pre_o[i] = run;
      run      = run + PCNT_W'(mask_i[i]);
    end
    total_o = run;
  end

endmodule
`default_nettype wire

// File: rtl/syncfifo_gather_4.sv
`default_nettype none
// ============================================================================
// Module      : syncfifo_gather_4
// Description : 4-to-1 merging FIFO. Up to four producers push one word each
//               per cycle into a shared circular buffer; accepted words are
//               stored in arrival order, lower input index first within a
//               cycle. A single consumer pops words tagged with their source.
// Ports       : clk, rst (sync, active-high), softreset (sync flush)
//               vldin[3:0], din[3:0][WID-1:0], ready[3:0] (combinational)
//               readout, dout[WID-1:0], source[1:0]
//               empty, full, count[15:0], overflow (combinational)
//               drops[3:0][7:0]  (only with SYNCFIFO_GATHER_DROPCNT_EN)
// Options     : `define SYNCFIFO_GATHER_DROPCNT_EN adds saturating per-input
//               counters of cycles in which a valid word was refused.
// Revision    : 1.0 - initial release
// ============================================================================
module syncfifo_gather_4
  import syncfifo_pkg::*;
#(
  parameter int WID   = 32,
  parameter int DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          softreset,
  input  logic [NPORTS-1:0]             vldin,
  input  logic [NPORTS-1:0][WID-1:0]    din,
  output logic [NPORTS-1:0]             ready,
  input  logic                          readout,
  output logic [WID-1:0]                dout,
  output logic [SRC_W-1:0]              source,
  output logic                          empty,
  output logic                          full,
  output logic [15:0]                   count,
  output logic                          overflow
`ifdef SYNCFIFO_GATHER_DROPCNT_EN
  ,
  output logic [NPORTS-1:0][7:0]        drops
`endif
);

  localparam int AWID = $clog2(DEPTH);
  localparam int CW   = AWID + 1;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [WID-1:0]   data;
  } gather_entry_t;

  gather_entry_t mem_q [DEPTH];

  logic [AWID-1:0] wptr_q, wptr_d;
  logic [AWID-1:0] rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q,  cnt_d;
  logic [CW-1:0]   free;
  logic            flush;
  logic            pop;
  logic [NPORTS-1:0] acc;

  logic [NPORTS-1:0][PCNT_W-1:0] pre_vld, pre_acc;
  logic [PCNT_W-1:0]             tot_vld, nacc;
  logic [NPORTS-1:0][AWID-1:0]   waddr;
  gather_entry_t                 head;

  assign flush = rst | softreset;

  gather_prefix_4 u_pre_vld (
    .mask_i  (vldin),
    .pre_o   (pre_vld),
    .total_o (tot_vld)
  );

  gather_prefix_4 u_pre_acc (
    .mask_i  (acc),
    .pre_o   (pre_acc),
    .total_o (nacc)
  );

  // Room is judged from the current occupancy only; a same-cycle pop never
  // frees a slot. An input only reports ready while it is actually offering
  // a word, so an idle input shows ready=0.
  always_comb begin
    free = CW'(DEPTH) - cnt_q;
    for (int i = 0; i < NPORTS; i++) begin
      ready[i] = vldin[i] & ~flush & (free > CW'(pre_vld[i]));
      waddr[i] = wptr_q + AWID'(pre_acc[i]);
    end
  end

  assign acc = vldin & ready;

  // Accepted words are a subset of the offered ones, so some valid input was
  // refused exactly when the two popcounts differ.
  assign overflow = (tot_vld != nacc);

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(DEPTH));
  assign count  = 16'(cnt_q);
  assign pop    = readout & ~empty;
  assign head   = mem_q[rptr_q];
  assign dout   = empty ? '0 : head.data;
  assign source = empty ? '0 : head.src;

  assign wptr_d = wptr_q + AWID'(nacc);
  assign rptr_d = rptr_q + AWID'(pop);
  assign cnt_d  = cnt_q + CW'(nacc) - CW'(pop);

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is not reset; acc is already zero during a flush.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORTS; i++) begin
      if (acc[i]) begin
        mem_q[waddr[i]] <= '{src: SRC_W'(i), data: din[i]};
      end
    end
  end

`ifdef SYNCFIFO_GATHER_DROPCNT_EN
  logic [NPORTS-1:0][7:0] drops_q;

  always_ff @(posedge clk) begin
    if (flush) begin
      drops_q <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (vldin[i] && !ready[i] && (drops_q[i] != 8'hFF)) begin
          drops_q[i] <= drops_q[i] + 8'd1;
        end
      end
    end
  end

  assign drops = drops_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_syncfifo_gather_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_syncfifo_gather_4
// Description : Self-checking bench for syncfifo_gather_4 (WID=32, DEPTH=8).
//               A queue-based reference model predicts every output each
//               cycle; table vectors and directed sequences add fixed
//               expectations for admission, ordering, wrap and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_syncfifo_gather_4;

  typedef logic [3:0][31:0] din_t;

  typedef struct {
    int         fill;
    logic [3:0] vld;
    logic [3:0] rdy;
    logic       ovf;
  } tv_t;

  logic        clk;
  logic        rst;
  logic        softreset;
  logic [3:0]  vldin;
  din_t        din;
  logic [3:0]  ready;
  logic        readout;
  logic [31:0] dout;
  logic [1:0]  source;
  logic        empty;
  logic        full;
  logic [15:0] count;
  logic        overflow;
`ifdef SYNCFIFO_GATHER_DROPCNT_EN
  logic [3:0][7:0] drops;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: FIFO contents as {src, data}, plus pointer positions.
  logic [33:0] mq[$];
  int mw = 0;
  int mr = 0;

  syncfifo_gather_4 #(.WID(32), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .softreset (softreset),
    .vldin     (vldin),
    .din       (din),
    .ready     (ready),
    .readout   (readout),
    .dout      (dout),
    .source    (source),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow)
`ifdef SYNCFIFO_GATHER_DROPCNT_EN
    ,
    .drops     (drops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready from the admission rule: input i is offered and fewer than
  // (DEPTH - occupancy) lower-index inputs are also offering.
  function automatic logic [3:0] m_ready(input logic [3:0] v, input logic fl);
    int free;
    int n;
    logic [3:0] r;
    r    = '0;
    free = 8 - mq.size();
    n    = 0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        if (!fl && free > n) r[i] = 1'b1;
        n++;
      end
    end
    return r;
  endfunction

  task automatic check_outputs();
    logic [3:0]  er;
    logic [33:0] hd;
    er = m_ready(vldin, rst | softreset);
    hd = (mq.size() > 0) ? mq[0] : 34'd0;
    chk("ready",    ready,    er);
    chk("overflow", overflow, |(vldin & ~er));
    chk("empty",    empty,    mq.size() == 0);
    chk("full",     full,     mq.size() == 8);
    chk("count",    count,    mq.size());
    chk("dout",     dout,     hd[31:0]);
    chk("source",   source,   hd[33:32]);
  endtask

  task automatic model_update();
    logic [3:0]  er;
    logic [33:0] tmp;
    logic [1:0]  s;
    if (rst || softreset) begin
      mq.delete();
      mw = 0;
      mr = 0;
    end else begin
      er = m_ready(vldin, 1'b0);
      if (readout && mq.size() > 0) begin
        tmp = mq.pop_front();
        mr  = (mr + 1) % 8;
      end
      for (int i = 0; i < 4; i++) begin
        if (er[i]) begin
          s = i[1:0];
          mq.push_back({s, din[i]});
          mw = (mw + 1) % 8;
        end
      end
    end
  endtask

  // One clock: drive, check combinational/registered outputs mid-cycle,
  // advance the model on the edge, return 1 time unit after the edge.
  task automatic cycle(input logic [3:0] v, input din_t d, input logic rd, input logic sr);
    vldin     = v;
    din       = d;
    readout   = rd;
    softreset = sr;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic din_t rnd_din();
    din_t d;
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    return d;
  endfunction

  task automatic fill(input int n);
    cycle(4'h0, '0, 1'b0, 1'b1);
    for (int k = 0; k < n; k++) cycle(4'b0001, rnd_din(), 1'b0, 1'b0);
  endtask

  tv_t tbl[8];
  din_t dd;

  initial begin
    tbl[0] = '{0, 4'b1111, 4'b1111, 1'b0};
    tbl[1] = '{6, 4'b1111, 4'b0011, 1'b1};
    tbl[2] = '{6, 4'b1100, 4'b1100, 1'b0};
    tbl[3] = '{7, 4'b1010, 4'b0010, 1'b1};
    tbl[4] = '{8, 4'b0001, 4'b0000, 1'b1};
    tbl[5] = '{5, 4'b1111, 4'b0111, 1'b1};
    tbl[6] = '{4, 4'b0000, 4'b0000, 1'b0};
    tbl[7] = '{7, 4'b0100, 4'b0100, 1'b0};

    // ---- reset with all inputs offering
    rst = 1'b1; softreset = 1'b0; readout = 1'b0; vldin = 4'hF; din = '0;
    @(posedge clk); #1;
    cycle(4'hF, rnd_din(), 1'b0, 1'b0);
    chk("rst_empty",  empty,  1);
    chk("rst_full",   full,   0);
    chk("rst_count",  count,  0);
    chk("rst_dout",   dout,   0);
    chk("rst_source", source, 0);
    rst = 1'b0;
    cycle(4'h0, '0, 1'b0, 1'b0);
    chk("rel_idle_ready", ready, 4'h0);
    cycle(4'b0101, rnd_din(), 1'b0, 1'b0);
    chk("rel_count", count, 2);

    // ---- table-driven admission vectors
    for (int e = 0; e < 8; e++) begin
      fill(tbl[e].fill);
      vldin = tbl[e].vld; din = rnd_din(); readout = 1'b0; softreset = 1'b0;
      @(negedge clk);
      check_outputs();
      chk($sformatf("tbl%0d_ready", e), ready, tbl[e].rdy);
      chk($sformatf("tbl%0d_ovf", e), overflow, tbl[e].ovf);
      @(posedge clk);
      model_update();
      #1;
    end

    // ---- burst of four, ordering by index
    cycle(4'h0, '0, 1'b0, 1'b1);
    dd[0] = 32'hA0A0_0001; dd[1] = 32'hB0B0_0002; dd[2] = 32'hC0C0_0003; dd[3] = 32'hD0D0_0004;
    cycle(4'hF, dd, 1'b0, 1'b0);
    chk("burst_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("burst_dout%0d", i), dout, dd[i]);
      chk($sformatf("burst_src%0d", i), source, i);
      cycle(4'h0, '0, 1'b1, 1'b0);
    end
    chk("burst_empty", empty, 1);

    // ---- partial admission at count 6
    cycle(4'h0, '0, 1'b0, 1'b1);
    cycle(4'hF, rnd_din(), 1'b0, 1'b0);
    cycle(4'b0011, rnd_din(), 1'b0, 1'b0);
    dd[0] = 32'h1111_0000; dd[1] = 32'h2222_0001; dd[2] = 32'h3333_0002; dd[3] = 32'h4444_0003;
    vldin = 4'hF; din = dd; readout = 1'b0; softreset = 1'b0;
    @(negedge clk);
    check_outputs();
    chk("part_ready", ready, 4'b0011);
    chk("part_ovf", overflow, 1);
    @(posedge clk); model_update(); #1;
    chk("part_count", count, 8);
    chk("part_full", full, 1);
    for (int k = 0; k < 6; k++) cycle(4'h0, '0, 1'b1, 1'b0);
    chk("part_head0", dout, 32'h1111_0000);
    chk("part_src0", source, 0);
    cycle(4'h0, '0, 1'b1, 1'b0);
    chk("part_head1", dout, 32'h2222_0001);
    chk("part_src1", source, 1);

    // ---- full with simultaneous pop: no room is created
    cycle(4'h0, '0, 1'b0, 1'b1);
    dd[0] = 32'h0; dd[1] = 32'h1; dd[2] = 32'h2; dd[3] = 32'h3;
    cycle(4'hF, dd, 1'b0, 1'b0);
    dd[0] = 32'h4; dd[1] = 32'h5; dd[2] = 32'h6; dd[3] = 32'h7;
    cycle(4'hF, dd, 1'b0, 1'b0);
    chk("fullpop_full", full, 1);
    vldin = 4'b0001; din = rnd_din(); readout = 1'b1; softreset = 1'b0;
    @(negedge clk);
    check_outputs();
    chk("fullpop_ready0", ready[0], 0);
    chk("fullpop_ovf", overflow, 1);
    @(posedge clk); model_update(); #1;
    chk("fullpop_count", count, 7);
    chk("fullpop_head", dout, 32'h1);

    // ---- wrap-around from pointer 6
    cycle(4'h0, '0, 1'b0, 1'b1);
    cycle(4'hF, rnd_din(), 1'b0, 1'b0);
    cycle(4'b0011, rnd_din(), 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cycle(4'h0, '0, 1'b1, 1'b0);
    chk("wrap_wptr6", dut.wptr_q, 6);
    chk("wrap_rptr6", dut.rptr_q, 6);
    chk("wrap_empty", empty, 1);
    dd[0] = 32'hCAFE_0000; dd[1] = 32'hBEEF_0001; dd[2] = 32'hDEAD_0002; dd[3] = 32'hF00D_0003;
    cycle(4'b1011, dd, 1'b0, 1'b0);
    chk("wrap_count", count, 3);
    chk("wrap_wptr1", dut.wptr_q, 1);
    chk("wrap_h0", {source, dout}, {2'd0, 32'hCAFE_0000});
    cycle(4'h0, '0, 1'b1, 1'b0);
    chk("wrap_h1", {source, dout}, {2'd1, 32'hBEEF_0001});
    cycle(4'h0, '0, 1'b1, 1'b0);
    chk("wrap_h2", {source, dout}, {2'd3, 32'hF00D_0003});
    cycle(4'h0, '0, 1'b1, 1'b0);
    chk("wrap_rptr1", dut.rptr_q, 1);

    // ---- softreset mid-traffic
    cycle(4'h0, '0, 1'b0, 1'b1);
    cycle(4'hF, rnd_din(), 1'b0, 1'b0);
    cycle(4'b0001, rnd_din(), 1'b0, 1'b0);
    chk("sr_pre_count", count, 5);
    cycle(4'hF, rnd_din(), 1'b1, 1'b1);
    chk("sr_count", count, 0);
    chk("sr_empty", empty, 1);
    chk("sr_wptr", dut.wptr_q, 0);
    chk("sr_rptr", dut.rptr_q, 0);

`ifdef SYNCFIFO_GATHER_DROPCNT_EN
    chk("drops_clr", drops, '0);
    fill(8);
    for (int k = 0; k < 300; k++) cycle(4'b0100, rnd_din(), 1'b0, 1'b0);
    chk("drops2_sat", drops[2], 8'd255);
    chk("drops0", drops[0], 8'd0);
    cycle(4'h0, '0, 1'b0, 1'b1);
    chk("drops_flush", drops, '0);
`endif

    // ---- randomized traffic against the model
    cycle(4'h0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 600; k++) begin
      cycle(4'($urandom_range(0, 15)), rnd_din(),
            ($urandom_range(0, 99) < 45), ($urandom_range(0, 59) == 0));
    end
    chk("rand_wptr", dut.wptr_q, mw);
    chk("rand_rptr", dut.rptr_q, mr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
